// File: rtl/score_text_renderer_pkg.sv
// Shared constants and types for the score text renderer: glyph indices,
// glyph geometry and the award FSM state type.
package score_pkg;

   localparam int GLYPH_ROWS  = 16;
   localparam int GLYPH_W     = 8;
   localparam int SCORE_CHARS = 11;

   localparam logic [4:0] GLYPH_S      = 5'd0;
   localparam logic [4:0] GLYPH_C      = 5'd1;
   localparam logic [4:0] GLYPH_O      = 5'd2;
   localparam logic [4:0] GLYPH_R      = 5'd3;
   localparam logic [4:0] GLYPH_E      = 5'd4;
   localparam logic [4:0] GLYPH_COLON  = 5'd5;
   localparam logic [4:0] GLYPH_SPACE  = 5'd6;
   localparam logic [4:0] GLYPH_DIGIT0 = 5'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ADD    = 2'd1,
      ST_COMMIT = 2'd2
   } score_add_state_t;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

endpackage

// File: rtl/score_text_renderer_if.sv
// Award request channel. An award transfers on a clock edge where
// pts_valid && pts_ready; pts_bcd must be stable while pts_valid is high.
interface score_text_renderer_if;
   logic        pts_valid;
   logic [15:0] pts_bcd;
   logic        pts_ready;

   modport master (output pts_valid, output pts_bcd, input pts_ready);
   modport slave  (input pts_valid, input pts_bcd, output pts_ready);
endinterface

// File: rtl/score_text_renderer_bcd_digit_add.sv
// Single BCD digit adder with carry in/out; operands are valid BCD digits.
module bcd_digit_add (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       carry_i,
   output logic [3:0] sum_o,
   output logic       carry_o
);
   logic [4:0] raw;

   always_comb begin
      raw = {1'b0, a_i} + {1'b0, b_i} + {4'b0, carry_i};
      if (raw > 5'd9) begin
         sum_o   = 4'(raw - 5'd10);
         carry_o = 1'b1;
      end else begin
         sum_o   = raw[3:0];
         carry_o = 1'b0;
      end
   end
endmodule

// File: rtl/score_text_renderer.sv
// BCD score keeper with a serial award adder and a "SCORE: dddd" text renderer.
// Optional `SCORE_LEADING_BLANK_EN blanks leading zero digits in the display.
module score_text_renderer
   import score_pkg::*;
#(
   parameter int SCORE_X = 16,
   parameter int SCORE_Y = 0
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  clear,
   score_text_renderer_if.slave  award,
   output logic [15:0]           score_bcd,
   input  logic [9:0]            DrawX,
   input  logic [9:0]            DrawY,
   output logic [9:0]            rom_addr,
   input  logic [7:0]            rom_data,
   output logic                  score_px,
   output score_add_state_t      dbg_state_o
);

   score_add_state_t state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        carry_q, carry_d;
   logic [15:0] pts_q, pts_d;
   logic [15:0] work_q, work_d;
   logic [15:0] score_q, score_d;
   logic [15:0] snap_q;

   logic [3:0]  add_sum;
   logic        add_cout;

   // One adder serves all four digits; the digit counter picks the lane.
   bcd_digit_add u_add (
      .a_i     (work_q[{cnt_q, 2'b00} +: 4]),
      .b_i     (pts_q[{cnt_q, 2'b00} +: 4]),
      .carry_i (carry_q),
      .sum_o   (add_sum),
      .carry_o (add_cout)
   );

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      carry_d         = carry_q;
      pts_d           = pts_q;
      work_d          = work_q;
      score_d         = score_q;
      award.pts_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            award.pts_ready = !clear;
            if (clear) begin
               score_d = '0;
            end else if (award.pts_valid) begin
               pts_d   = {clamp_digit(award.pts_bcd[15:12]), clamp_digit(award.pts_bcd[11:8]),
                          clamp_digit(award.pts_bcd[7:4]),   clamp_digit(award.pts_bcd[3:0])};
               work_d  = score_q;
               carry_d = 1'b0;
               cnt_d   = 2'd0;
               state_d = ST_ADD;
            end
         end
         ST_ADD: begin
            if (clear) begin
               score_d = '0;
               state_d = ST_IDLE;
            end else begin
               work_d[{cnt_q, 2'b00} +: 4] = add_sum;
               carry_d = add_cout;
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            score_d = clear ? 16'h0000 : (carry_q ? 16'h9999 : work_q);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         pts_q   <= '0;
         work_q  <= '0;
         score_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         pts_q   <= pts_d;
         work_q  <= work_d;
         score_q <= score_d;
      end
   end

   assign score_bcd   = score_q;
   assign dbg_state_o = state_q;

   logic [10:0] dx, dy;
   logic        inbox_d, inbox_q;
   logic [3:0]  slot;
   logic [3:0]  digit;
   logic [4:0]  glyph;
   logic [9:0]  addr_d, addr_q;
   logic [2:0]  xlo_q;
   logic        px_q;

   always_comb begin
      dx      = {1'b0, DrawX} - 11'(SCORE_X);
      dy      = {1'b0, DrawY} - 11'(SCORE_Y);
      inbox_d = ({1'b0, DrawX} >= 11'(SCORE_X)) && (dx < 11'(SCORE_CHARS * GLYPH_W)) &&
                ({1'b0, DrawY} >= 11'(SCORE_Y)) && (dy < 11'(GLYPH_ROWS));
      slot    = dx[6:3];
      case (slot)
         4'd7:    digit = snap_q[15:12];
         4'd8:    digit = snap_q[11:8];
         4'd9:    digit = snap_q[7:4];
         default: digit = snap_q[3:0];
      endcase
      case (slot)
         4'd0:    glyph = GLYPH_S;
         4'd1:    glyph = GLYPH_C;
         4'd2:    glyph = GLYPH_O;
         4'd3:    glyph = GLYPH_R;
         4'd4:    glyph = GLYPH_E;
         4'd5:    glyph = GLYPH_COLON;
         4'd6:    glyph = GLYPH_SPACE;
         default: glyph = GLYPH_DIGIT0 + {1'b0, digit};
      endcase
`ifdef SCORE_LEADING_BLANK_EN
      // A digit is leading only if it and every more significant digit are zero.
      if ((slot == 4'd7 && snap_q[15:12] == 4'd0) ||
          (slot == 4'd8 && snap_q[15:8]  == 8'd0) ||
          (slot == 4'd9 && snap_q[15:4]  == 12'd0))
         glyph = GLYPH_SPACE;
`endif
      addr_d = inbox_d ? {glyph, dy[3:0], 1'b0} >> 1 : 10'd0;
   end

   // Snapshot only at the frame origin so a frame never mixes two scores.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         snap_q  <= '0;
         addr_q  <= '0;
         inbox_q <= 1'b0;
         xlo_q   <= '0;
         px_q    <= 1'b0;
      end else begin
         if (DrawX == 10'd0 && DrawY == 10'd0) snap_q <= score_q;
         addr_q  <= addr_d;
         inbox_q <= inbox_d;
         xlo_q   <= DrawX[2:0];
         px_q    <= inbox_q && rom_data[3'd7 - xlo_q];
      end
   end

   assign rom_addr = addr_q;
   assign score_px = px_q;

endmodule
